// File: rtl/dcache_wt_pkg.sv
// Shared types and helpers for the write-through data cache.
// Optional statistics counters are enabled with the DCACHE_STATS_EN macro.
package dcache_wt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

  localparam logic MEM_WORD = 1'b1;
  localparam logic MEM_BYTE = 1'b0;

  localparam int LINE_BYTES = 16;

  // Byte lanes touched by an access: all four for a word, one-hot for a byte.
  function automatic logic [3:0] byte_en(input logic size, input logic [1:0] lo);
    if (size == MEM_WORD) return 4'b1111;
    return 4'b0001 << lo;
  endfunction

endpackage

// File: rtl/dcache_wt_if.sv
// Memory-side bus of the data cache: line refill and write-through handshakes.
interface dcache_wt_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_start;
  logic              mem_read_rdy;
  logic [127:0]      mem_rdata;
  logic              mem_write_start;
  logic              mem_write_done;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wbe;

  modport master (
    output mem_addr, mem_read_start, mem_write_start, mem_wdata, mem_wbe,
    input  mem_read_rdy, mem_rdata, mem_write_done
  );

  modport slave (
    input  mem_addr, mem_read_start, mem_write_start, mem_wdata, mem_wbe,
    output mem_read_rdy, mem_rdata, mem_write_done
  );

endinterface

// File: rtl/dcache_array.sv
// Direct-mapped tag/valid/data storage: one combinational read port,
// one full-line write port (refill) and one byte-masked word write port (store hit).
module dcache_array #(
  parameter  int LINES = 16,
  parameter  int TAG_W = 24,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [3:0][31:0]      rd_line,
  input  logic                  line_we,
  input  logic [IDX_W-1:0]      line_idx,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic [127:0]          line_data,
  input  logic                  word_we,
  input  logic [IDX_W-1:0]      word_idx,
  input  logic [1:0]            word_sel,
  input  logic [31:0]           word_data,
  input  logic [3:0]            word_be
);

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [3:0][3:0][7:0]  data_q [LINES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        valid_q <= '0;
    else if (line_we) valid_q[line_idx] <= 1'b1;
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide
  // whether their contents mean anything, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end
    if (word_we) begin
      for (int b = 0; b < 4; b++) begin
        if (word_be[b]) data_q[word_idx][word_sel][b] <= word_data[8*b +: 8];
      end
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache for a memory stage.
// Define DCACHE_STATS_EN to add the stat_hits / stat_misses counters.
module dcache_wt
  import dcache_wt_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  dcache_wt_if.master       mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  state_e state_q, state_d;

  logic [ADDR_W-1:2] txn_addr_q;
  logic [31:0]       txn_wdata_q;
  logic [3:0]        txn_wbe_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [1:0]        req_word;
  logic [31:0]       store_data;
  logic [3:0]        store_be;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [3:0][31:0]  rd_line;
  logic              hit;
  logic              start_txn;

  assign req_idx    = req_addr[OFF_W +: IDX_W];
  assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
  assign req_word   = req_addr[3:2];
  assign store_data = (req_size == MEM_WORD) ? req_wdata : {4{req_wdata[7:0]}};
  assign store_be   = byte_en(req_size, req_addr[1:0]);
  assign hit        = rd_valid && (rd_tag == req_tag);
  assign start_txn  = (state_q == ST_IDLE) && req_valid && (req_we || !hit);

  dcache_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (req_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .line_we   ((state_q == ST_REFILL) && mem.mem_read_rdy),
    .line_idx  (txn_addr_q[OFF_W +: IDX_W]),
    .line_tag  (txn_addr_q[ADDR_W-1 -: TAG_W]),
    .line_data (mem.mem_rdata),
    .word_we   ((state_q == ST_IDLE) && req_valid && req_we && hit),
    .word_idx  (req_idx),
    .word_sel  (req_word),
    .word_data (store_data),
    .word_be   (store_be)
  );

  // NOTE: every register here updates with <= so all flops sample the
  // pre-edge values together, independent of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // The transaction is latched so the bus stays stable while the stage stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txn_addr_q  <= '0;
      txn_wdata_q <= '0;
      txn_wbe_q   <= '0;
    end else if (start_txn) begin
      txn_addr_q  <= req_addr[ADDR_W-1:2];
      txn_wdata_q <= store_data;
      txn_wbe_q   <= store_be;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_we)    state_d = ST_WRITE;
        else if (req_valid && !hit) state_d = ST_REFILL;
      end
      ST_REFILL: if (mem.mem_read_rdy)   state_d = ST_IDLE;
      ST_WRITE:  if (mem.mem_write_done) state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path through
  // this block leaves a value held over and no latch is inferred.
  always_comb begin
    rdata               = '0;
    stall               = 1'b0;
    mem.mem_addr        = '0;
    mem.mem_read_start  = 1'b0;
    mem.mem_write_start = 1'b0;
    mem.mem_wdata       = '0;
    mem.mem_wbe         = '0;
    if (!reset) begin
      rdata = rd_line[req_word];
      unique case (state_q)
        ST_IDLE: stall = req_valid && (req_we || !hit);
        ST_REFILL: begin
          stall              = 1'b1;
          mem.mem_read_start = 1'b1;
          mem.mem_addr       = {txn_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
        ST_WRITE: begin
          stall               = !mem.mem_write_done;
          mem.mem_write_start = 1'b1;
          mem.mem_addr        = {txn_addr_q, 2'b00};
          mem.mem_wdata       = txn_wdata_q;
          mem.mem_wbe         = txn_wbe_q;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // The load replayed right after a refill is the tail of a miss, not a new hit.
  logic replay_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      replay_q    <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && req_valid && !req_we && hit && !replay_q)
        stat_hits <= stat_hits + 32'd1;
      if ((state_q == ST_IDLE) && (state_d == ST_REFILL))
        stat_misses <= stat_misses + 32'd1;
      replay_q <= (state_q == ST_REFILL) && mem.mem_read_rdy;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Randomised scoreboard bench for dcache_wt against a line-residency and
// flat-memory reference model; a bus responder plays the backing memory.
module tb_dcache_wt;

  localparam int LINES  = 16;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_size;
  logic [31:0] req_addr, req_wdata, rdata;
  logic        stall;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  dcache_wt_if #(.ADDR_W(ADDR_W)) mem ();

  dcache_wt #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rdata     (rdata),
    .stall     (stall),
    .mem       (mem)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // ---------------- reference model ----------------
  function automatic bit [31:0] seed(input bit [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  bit [31:0] ref_mem  [bit [31:0]];
  bit [31:0] phys_mem [bit [31:0]];
  bit        res_valid [LINES];
  bit [31:0] res_line  [LINES];
  int        exp_hits = 0, exp_misses = 0;

  function automatic bit [31:0] ref_rd(input bit [31:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : seed(wa);
  endfunction

  function automatic bit [31:0] phys_rd(input bit [31:0] wa);
    return phys_mem.exists(wa) ? phys_mem[wa] : seed(wa);
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d, input bit [3:0] be);
    bit [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    bit        is_store;
    bit [31:0] data;
    int        stalls;
    bit [31:0] waddr;
    bit [31:0] wdata;
    bit [3:0]  wbe;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- memory responder ----------------
  int        rd_lat = 1, wr_lat = 1;
  bit        force_rdy = 0, junk_en = 1;
  bit [31:0] exp_refill_addr;
  bit [31:0] obs_waddr, obs_wdata;
  bit [3:0]  obs_wbe;

  initial begin
    int        rcnt = 0, wcnt = 0;
    bit [31:0] rd_addr0;
    logic [127:0] line;
    mem.mem_read_rdy   = 1'b0;
    mem.mem_write_done = 1'b0;
    mem.mem_rdata      = '0;
    forever begin
      @(negedge clk);
      if (mem.mem_read_start) begin
        rcnt++;
        if (rcnt == 1) rd_addr0 = mem.mem_addr;
        else check("refill_addr_stable", mem.mem_addr, rd_addr0);
        mem.mem_read_rdy = (rcnt == rd_lat);
        if (rcnt == rd_lat) begin
          check("refill_addr", mem.mem_addr, exp_refill_addr);
          for (int k = 0; k < 4; k++) line[32*k +: 32] = phys_rd((mem.mem_addr >> 2) + k);
          mem.mem_rdata = line;
        end else begin
          mem.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        rcnt = 0;
        mem.mem_read_rdy = force_rdy | (junk_en & ($urandom_range(0, 1) == 1));
        mem.mem_rdata    = {$urandom, $urandom, $urandom, $urandom};
      end
      if (mem.mem_write_start) begin
        wcnt++;
        if (wcnt == 1) begin
          obs_waddr = mem.mem_addr;
          obs_wdata = mem.mem_wdata;
          obs_wbe   = mem.mem_wbe;
        end else begin
          check("write_addr_stable", mem.mem_addr, obs_waddr);
          check("write_data_stable", mem.mem_wdata, obs_wdata);
          check("write_wbe_stable", {28'd0, mem.mem_wbe}, {28'd0, obs_wbe});
        end
        mem.mem_write_done = (wcnt == wr_lat);
        if (wcnt == wr_lat)
          phys_mem[obs_waddr >> 2] = merge(phys_rd(obs_waddr >> 2), obs_wdata, obs_wbe);
      end else begin
        wcnt = 0;
        mem.mem_write_done = force_rdy | (junk_en & ($urandom_range(0, 1) == 1));
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int   stall_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        stall_cnt = 0;
      end else if (!req_valid) begin
        check("idle_stall", {31'd0, stall}, 32'd0);
      end else if (stall) begin
        stall_cnt++;
      end else if (exp_q.size() == 0) begin
        check("completion_pending", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check(e.is_store ? "store_stalls" : "load_stalls", stall_cnt, e.stalls);
        if (e.is_store) begin
          check("store_addr", obs_waddr, e.waddr);
          check("store_wdata", obs_wdata, e.wdata);
          check("store_wbe", {28'd0, obs_wbe}, {28'd0, e.wbe});
        end else begin
          check("load_rdata", rdata, e.data);
        end
        stall_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic issue(input bit we, input bit size, input bit [31:0] addr,
                       input bit [31:0] wdata, input int lat);
    exp_t      e;
    bit [31:0] line = addr >> 4;
    int        idx  = int'(line % LINES);
    bit        done = 0;
    e.is_store = we;
    if (!we) begin
      if (res_valid[idx] && res_line[idx] == line) begin
        e.stalls = 0;
        exp_hits++;
      end else begin
        e.stalls = lat + 1;
        res_valid[idx] = 1;
        res_line[idx]  = line;
        exp_misses++;
      end
      e.data = ref_rd(addr >> 2);
      rd_lat = lat;
      exp_refill_addr = addr & 32'hFFFF_FFF0;
    end else begin
      e.wbe    = size ? 4'hF : (4'h1 << addr[1:0]);
      e.wdata  = size ? wdata : {4{wdata[7:0]}};
      e.waddr  = addr & 32'hFFFF_FFFC;
      e.stalls = lat;
      ref_mem[addr >> 2] = merge(ref_rd(addr >> 2), e.wdata, e.wbe);
      wr_lat = lat;
    end
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    for (int c = 0; c < 64 && !done; c++) begin
      #4;
      if (!stall) done = 1;
      else @(negedge clk);
    end
    if (!done) begin
      check("access_timeout", {31'd0, stall}, 32'd0);
      finish_run();
    end
  endtask

  task automatic preload(input bit [31:0] addr, input bit [31:0] val);
    ref_mem[addr >> 2]  = val;
    phys_mem[addr >> 2] = val;
  endtask

  task automatic check_bus_zero(input string tag);
    check({tag, "_read_start"}, {31'd0, mem.mem_read_start}, 32'd0);
    check({tag, "_write_start"}, {31'd0, mem.mem_write_start}, 32'd0);
    check({tag, "_mem_addr"}, mem.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem.mem_wdata, 32'd0);
    check({tag, "_mem_wbe"}, {28'd0, mem.mem_wbe}, 32'd0);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

`ifdef DCACHE_STATS_EN
  task automatic check_stats(input string tag);
    check({tag, "_stat_hits"}, stat_hits, exp_hits);
    check({tag, "_stat_misses"}, stat_misses, exp_misses);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    miscompares++;
    finish_run();
  end

  initial begin
    bit [31:0] bases [4];
    bit        we, sz;
    bit [31:0] a;
    bases = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'hFFFF_FF00};

    // Reset with a store request present: every output must stay quiet.
    reset     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 1'b1;
    req_addr  = 32'h100;
    req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    check_bus_zero("reset");
    check("reset_rdata", rdata, 32'd0);
    req_valid = 1'b0;
    reset     = 1'b0;
`ifdef DCACHE_STATS_EN
    idle(1);
    #1 check_stats("after_reset");
`endif

    preload(32'h100, 32'h1111_1111);
    preload(32'h104, 32'h2222_2222);
    preload(32'h108, 32'h3333_3333);
    preload(32'h10C, 32'h4444_4444);

    issue(0, 1, 32'h100, 0, 3);           // cold miss, 3-cycle handshake
    issue(0, 1, 32'h104, 0, 2);           // hit in the same line
`ifdef DCACHE_STATS_EN
    idle(1);
    #1 check_stats("first_hit");
`endif
    issue(1, 0, 32'h102, 32'h0000_00AB, 2); // byte store hit
    issue(0, 1, 32'h100, 0, 1);           // sees merged byte
    issue(1, 1, 32'h800, 32'hCAFE_F00D, 1); // store miss, no allocate
    issue(0, 1, 32'h800, 0, 2);           // must still miss
    issue(0, 1, 32'h100, 0, 1);
    issue(0, 1, 32'h100 + 16 * LINES, 0, 2); // conflict evicts
    issue(0, 1, 32'h100, 0, 1);           // misses again
    issue(0, 1, 32'h10B, 0, 1);           // word access ignores addr[1:0]
    idle(2);

    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 2) == 0);
      sz = ($urandom_range(0, 1) == 1);
      a  = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 255));
      issue(we, sz, a, $urandom, we ? $urandom_range(1, 3) : $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);
`ifdef DCACHE_STATS_EN
    #1 check_stats("random");
`endif

    // Reset in the middle of a refill, then late ready pulses.
    rd_lat = 10;
    exp_refill_addr = 32'h5000;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 1'b1;
    req_addr  = 32'h5000;
    repeat (3) @(negedge clk);
    #1;
    check("mid_refill_start", {31'd0, mem.mem_read_start}, 32'd1);
    reset     = 1'b1;
    req_valid = 1'b0;
    for (int l = 0; l < LINES; l++) res_valid[l] = 0;
    exp_hits   = 0;
    exp_misses = 0;
    #1;
    check_bus_zero("mid_reset");
    check("mid_reset_rdata", rdata, 32'd0);
    force_rdy = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1 check_bus_zero("late_rdy");
    end
    force_rdy = 0;
    issue(0, 1, 32'h104, 0, 2);           // every line invalid: must miss
    idle(2);
`ifdef DCACHE_STATS_EN
    #1 check_stats("post_reset");
`endif

    check("queue_drained", exp_q.size(), 0);
    finish_run();
  end

endmodule

// File: doc/dcache_wt.md
DCACHE_WT -- requirements
Module: dcache_wt

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines (power of two, 2..256).
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  memory-stage access present this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  1  1 = word, 0 = byte.
REQ-008 req_addr  in  ADDR_W  byte address.
REQ-009 req_wdata  in  32  store data; byte stores use bits [7:0].
REQ-010 rdata  out  32  aligned word containing req_addr.
REQ-011 stall  out  1  memory stage holds while high.
REQ-012 mem_addr  out  ADDR_W  line-aligned on refill, word-aligned on write.
REQ-013 mem_read_start / mem_read_rdy  out / in  1  line refill handshake.
REQ-014 mem_rdata  in  128  refill line; word k at bits [32k+31:32k].
REQ-015 mem_write_start / mem_write_done  out / in  1  write-through handshake.
REQ-016 mem_wdata  out  32  write data, store byte replicated to all lanes.
REQ-017 mem_wbe  out  4  byte enables: 4'b1111 for word, one-hot addr[1:0] for byte.

Function
REQ-018 Line = 16 bytes; index = addr[3+log2(LINES):4]; tag = remaining upper bits; word select = addr[3:2].
REQ-019 FSM states: IDLE, REFILL, WRITE.
REQ-020 Read hit (IDLE, valid && tag match): rdata valid combinationally in the same cycle; stall=0.
REQ-021 Read miss in IDLE: stall=1 in the same cycle; next state REFILL.
REQ-022 REFILL: mem_read_start=1 and mem_addr=line address until the cycle mem_read_rdy=1. In that cycle, capture mem_rdata, set tag and valid, and return to IDLE. The replayed load then hits, so miss latency = handshake cycles + 1.
REQ-023 Any store in IDLE: stall=1; next state WRITE.
REQ-024 On IDLE->WRITE, a store hit updates only the enabled byte lanes of the cached word. A store miss does not allocate.
REQ-025 WRITE: mem_write_start=1 and mem_addr/mem_wdata/mem_wbe held stable until mem_write_done=1.
REQ-026 In the cycle mem_write_done=1: stall=0 and next state IDLE. The store is not reissued.
REQ-027 stall = (IDLE && req_valid && (miss || req_we)) || REFILL || (WRITE && !mem_write_done).
REQ-028 req_valid=0 in IDLE: no state change; stall=0.
REQ-029 mem_read_rdy or mem_write_done outside its matching state is ignored.
REQ-030 Word accesses ignore addr[1:0].
REQ-031 Refilling a line that is already valid overwrites it, regardless of its tag.

Reset
REQ-032 Asynchronous reset forces IDLE and clears every valid bit; data and tag arrays are not cleared.
REQ-033 During reset: stall=0, mem_read_start=0, mem_write_start=0, mem_wbe=0, mem_addr=0, mem_wdata=0, rdata=0.
REQ-034 Reset during REFILL or WRITE abandons the transaction; a late rdy or done is ignored per REQ-029.

Configuration
REQ-035 Macro DCACHE_STATS_EN adds outputs stat_hits and stat_misses (32 bits each, reset to 0, wrapping).
REQ-036 stat_hits increments once per read hit that completes with stall=0; stat_misses increments once per IDLE->REFILL transition.
REQ-037 Without DCACHE_STATS_EN the ports and counters do not exist; all other behaviour is identical.

Structure
REQ-038 The shared package holds the FSM state encoding, MEM_WORD/MEM_BYTE, LINE_BYTES=16 and the byte-enable decode function.
REQ-039 The tag/valid/data storage is sub-module dcache_array: one read port, one line-write port, one byte-masked word-write port.

Verification
REQ-040 After reset, load 0x100 with refill data word0=0x11111111 and rdy after 3 cycles: stall high for 4 cycles, then rdata=0x11111111; stat_misses=1.
REQ-041 Load 0x104 immediately after: stall=0 in the same cycle, rdata = word1 of the line; stat_hits=1.
REQ-042 Byte store 0xAB to 0x102 (line cached), done after 2 cycles: mem_wbe=4'b0100, mem_wdata=0xABABABAB, stall released in the done cycle; a later load of 0x100 returns 0x11AB1111.
REQ-043 Store miss to 0x800: write-through only; the next load to 0x800 misses (REFILL entered).
REQ-044 Conflict: load 0x100 then 0x100+16*LINES: second load refills and evicts; reloading 0x100 misses.
REQ-045 Assert reset mid-REFILL, then pulse mem_read_rdy: FSM stays IDLE, no line valid, all outputs zero.
